digit_scan_seq: RTL and testbench

//   Time-multiplexed scan sequencer for an 8-digit common-anode 7-segment display.

---
 rtl/digit_scan_seq.sv | 184 ++++++++++++++++++
 tb/tb_digit_scan_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_seq.sv
// digit_scan_seq
//   Scan sequencer for an 8-digit common-anode 7-segment display. Drives the
//   select lines and enables of a downstream 3-to-8 digit-select decoder.
//   It also drives the active-low segment pattern of the selected digit.
//   A blanking gap between digits keeps the decoder disabled, which suppresses
//   ghosting. A one-clock frame_tick marks the start of each new frame.
//   Every output is a flop, so no input reaches an output combinationally.
//
// Parameters
//   DIV    clocks each digit is shown (>= 1)
//   BLANK  clocks the decoder is disabled between digits (>= 0, 0 = no gap)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous reset, active low
//   en          in   1 = scanning runs, 0 = display off
//   digits_on   in   [2:0] highest digit index scanned
//   disp_data   in   [31:0] nibble i is shown on digit i
//   C,B,A       out  digit select, {C,B,A} = current digit index
//   G1          out  decoder enable, active high
//   G2A,G2B     out  decoder enables, active low
//   seg         out  [7:0] {dp,g,f,e,d,c,b,a}, active low, dp always off
//   frame_tick  out  pulse on the first shown cycle of digit 0 after a wrap
module digit_scan_seq #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  digits_on,
    input  logic [31:0] disp_data,
    output logic        C,
    output logic        B,
    output logic        A,
    output logic        G1,
    output logic        G2A,
    output logic        G2B,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int unsigned CW = $clog2(DIV + BLANK + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    cba_q, cba_d;
    logic          g1_q, g1_d;
    logic          g2n_q, g2n_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick_q, tick_d;
    logic          adv;
    logic          show_d;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] p;
        case (n)
            4'h0: p = 8'hC0;
            4'h1: p = 8'hF9;
            4'h2: p = 8'hA4;
            4'h3: p = 8'hB0;
            4'h4: p = 8'h99;
            4'h5: p = 8'h92;
            4'h6: p = 8'h82;
            4'h7: p = 8'hF8;
            4'h8: p = 8'h80;
            4'h9: p = 8'h90;
            4'hA: p = 8'h88;
            4'hB: p = 8'h83;
            4'hC: p = 8'hC6;
            4'hD: p = 8'hA1;
            4'hE: p = 8'h86;
            default: p = 8'h8E;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        tick_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (!en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (BLANK > 0) state_d = S_BLANK;
                    else           adv     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BLANK: begin
                if (!en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                    adv     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // digits_on is only looked at when a digit ends
        if (adv) begin
            if (idx_q >= digits_on) begin
                idx_d  = '0;
                tick_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        // Outputs are derived from the next state so they are registered
        // on the same edge as the state itself.
        show_d = (state_d == S_SHOW);
        g1_d   = show_d;
        g2n_d  = ~show_d;
        cba_d  = (state_d == S_IDLE) ? 3'd0 : idx_d;
        seg_d  = show_d ? hex7(disp_data[{idx_d, 2'b00} +: 4]) : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            cba_q   <= '0;
            g1_q    <= 1'b0;
            g2n_q   <= 1'b1;
            seg_q   <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cba_q   <= cba_d;
            g1_q    <= g1_d;
            g2n_q   <= g2n_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign {C, B, A}  = cba_q;
    assign G1         = g1_q;
    assign G2A        = g2n_q;
    assign G2B        = g2n_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan_seq.sv
module tb_digit_scan_seq;

    localparam int DIVP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  digits_on;
    logic [31:0] disp_data;

    logic C_x, B_x, A_x, G1_x, G2A_x, G2B_x, ft_x;
    logic C_z, B_z, A_z, G1_z, G2A_z, G2B_z, ft_z;
    logic [7:0] seg_x, seg_z;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: one "time within digit" counter per instance
    bit          m_run  [2];
    int          m_idx  [2];
    int          m_t    [2];
    bit          m_tick [2];
    logic [31:0] m_dd   [2];
    int          m_blank[2] = '{2, 0};

    logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    digit_scan_seq #(.DIV(4), .BLANK(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_on(digits_on), .disp_data(disp_data),
        .C(C_x), .B(B_x), .A(A_x), .G1(G1_x), .G2A(G2A_x), .G2B(G2B_x),
        .seg(seg_x), .frame_tick(ft_x)
    );

    digit_scan_seq #(.DIV(4), .BLANK(0)) u_b0 (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_on(digits_on), .disp_data(disp_data),
        .C(C_z), .B(B_z), .A(A_z), .G1(G1_z), .G2A(G2A_z), .G2B(G2B_z),
        .seg(seg_z), .frame_tick(ft_z)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_run[m] = 0; m_idx[m] = 0; m_t[m] = 0; m_tick[m] = 0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            m_dd[m] = disp_data;
            if (!rst_n || !en) begin
                m_run[m] = 0; m_idx[m] = 0; m_t[m] = 0; m_tick[m] = 0;
            end else if (!m_run[m]) begin
                m_run[m] = 1; m_idx[m] = 0; m_t[m] = 0; m_tick[m] = 0;
            end else begin
                m_tick[m] = 0;
                m_t[m]++;
                if (m_t[m] == DIVP + m_blank[m]) begin
                    m_t[m] = 0;
                    if (m_idx[m] >= int'(digits_on)) begin
                        m_idx[m] = 0;
                        m_tick[m] = 1;
                    end else begin
                        m_idx[m]++;
                    end
                end
            end
        end
    endtask

    function automatic logic [14:0] expect_vec(int m);
        bit         show;
        logic [2:0] cba;
        logic [7:0] s;
        show = m_run[m] && (m_t[m] < DIVP);
        cba  = m_run[m] ? 3'(m_idx[m]) : 3'd0;
        s    = show ? HEX[m_dd[m][4*m_idx[m] +: 4]] : 8'hFF;
        return {cba, show, !show, !show, s, m_tick[m]};
    endfunction

    task automatic check_all(input string tag);
        logic [14:0] o0, o1, e0, e1;
        o0 = {C_x, B_x, A_x, G1_x, G2A_x, G2B_x, seg_x, ft_x};
        o1 = {C_z, B_z, A_z, G1_z, G2A_z, G2B_z, seg_z, ft_z};
        e0 = expect_vec(0);
        e1 = expect_vec(1);
        vectors++;
        assert (o0 === e0) else begin
            miscompares++;
            $error("FAIL %s blank2 observed=%h expected=%h", tag, o0, e0);
        end
        vectors++;
        assert (o1 === e1) else begin
            miscompares++;
            $error("FAIL %s blank0 observed=%h expected=%h", tag, o1, e1);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic check_bound(input string tag, input int guard, input int limit);
        vectors++;
        assert (guard < limit) else begin
            miscompares++;
            $error("FAIL %s timeout observed=%0d expected<%0d", tag, guard, limit);
        end
    endtask

    initial begin
        int guard;
        int ticks_x, ticks_z;

        // 1: reset and idle
        rst_n = 1'b0; en = 1'b0; digits_on = 3'd7; disp_data = 32'h76543210;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("idle_hold");

        // 2: full 8-digit scan, count frame ticks over 100 cycles
        en = 1'b1;
        ticks_x = 0; ticks_z = 0;
        for (int i = 0; i < 100; i++) begin
            step("scan8");
            if (ft_x) ticks_x++;
            if (ft_z) ticks_z++;
        end
        vectors++;
        assert (ticks_x === 2) else begin
            miscompares++;
            $error("FAIL ticks_blank2 observed=%0d expected=%0d", ticks_x, 2);
        end
        vectors++;
        assert (ticks_z === 3) else begin
            miscompares++;
            $error("FAIL ticks_blank0 observed=%0d expected=%0d", ticks_z, 3);
        end

        // 3: three digits, then lower digits_on while on digit 3
        digits_on = 3'd2; disp_data = 32'hFEDCBA98;
        for (int i = 0; i < 40; i++) step("scan3");
        digits_on = 3'd7;
        guard = 0;
        while (!(m_idx[0] == 3 && m_t[0] == 0) && guard < 200) begin
            step("seek_d3");
            guard++;
        end
        check_bound("seek_d3", guard, 200);
        step("d3");
        digits_on = 3'd1;
        for (int i = 0; i < 20; i++) step("lower_on");

        // 4 is covered throughout by the BLANK=0 instance; run digits_on=3
        digits_on = 3'd3;
        for (int i = 0; i < 40; i++) step("scan4");

        // 5: disable on 2nd show cycle of digit 3, then re-enable
        digits_on = 3'd7;
        guard = 0;
        while (!(m_idx[0] == 3 && m_t[0] == 1) && guard < 200) begin
            step("seek_d3s2");
            guard++;
        end
        check_bound("seek_d3s2", guard, 200);
        en = 1'b0;
        step("disable");
        step("disabled");
        en = 1'b1;
        step("reenable");
        vectors++;
        assert ({G1_x, ft_x, C_x, B_x, A_x} === 5'b10000) else begin
            miscompares++;
            $error("FAIL reenable_d0 observed=%b expected=%b", {G1_x, ft_x, C_x, B_x, A_x}, 5'b10000);
        end

        // 6: async reset mid-blank, then a nibble change mid-show
        guard = 0;
        while (!(m_run[0] && m_t[0] == DIVP) && guard < 200) begin
            step("seek_blank");
            guard++;
        end
        check_bound("seek_blank", guard, 200);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_held");
        rst_n = 1'b1;
        step("rst_release");
        guard = 0;
        while (!(m_run[0] && m_idx[0] == 0 && m_t[0] == 1) && guard < 200) begin
            step("seek_d0");
            guard++;
        end
        check_bound("seek_d0", guard, 200);
        disp_data[3:0] = disp_data[3:0] + 4'd5;
        step("nibble_chg");

        // randomized soak
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(99) >= 2);
            if ($urandom_range(99) < 5) digits_on = 3'($urandom_range(7));
            if ($urandom_range(99) < 30) disp_data = $urandom;
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
